rsa_word_loader: RTL and testbench

Input-side deserializer placed directly upstream of the RSA core. It accepts the operand frame (message, key, modulus) as a stream of narrow words over a valid/ready handshake. It assembles the three MOD_WIDTH-bit operands and presents them together to the core's i_valid/i_ready input port. A framing check on i_last rejects malformed frames without disturbing the core.

---
 rtl/rsa_word_loader.sv | 107 ++++++++++
 tb/tb_rsa_word_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_word_loader.sv
// rsa_word_loader: deserializes a framed word stream (msg, key, modulus)
// into three MOD_WIDTH-bit operands and offers them to the RSA core.
module rsa_word_loader #(
  parameter int unsigned MOD_WIDTH  = 256,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [MOD_WIDTH-1:0]  o_msg,
  output logic [MOD_WIDTH-1:0]  o_key,
  output logic [MOD_WIDTH-1:0]  o_modulus,
  output logic                  o_frame_err
);

  localparam int unsigned WPO   = MOD_WIDTH / WORD_WIDTH;
  localparam int unsigned FRAME = 3 * WPO;
  localparam int unsigned CNT_W = $clog2(FRAME);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [MOD_WIDTH-1:0] msg_q, msg_d;
  logic [MOD_WIDTH-1:0] key_q, key_d;
  logic [MOD_WIDTH-1:0] mod_q, mod_d;
  logic                 accept;
  logic                 last_slot;

  // Handshake flags decode from state only; no input reaches them combinationally.
  assign i_ready     = (state_q == ST_LOAD);
  assign o_valid     = (state_q == ST_SEND);
  assign accept      = i_ready & i_valid;
  assign last_slot   = (cnt_q == CNT_W'(FRAME - 1));
  assign o_frame_err = err_q;
  assign o_msg       = msg_q;
  assign o_key       = key_q;
  assign o_modulus   = mod_q;

  // Next state, word counter and framing-error decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (last_slot && i_last) begin
            state_d = ST_SEND;
            cnt_d   = '0;
          end else if (i_last || last_slot) begin
            // Short or long frame: discard and restart counting.
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SEND: begin
        if (o_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Steer each accepted word into its operand slice, LS word first.
  always_comb begin
    msg_d = msg_q;
    key_d = key_q;
    mod_d = mod_q;
    if (accept) begin
      for (int k = 0; k < int'(WPO); k++) begin
        if (cnt_q == CNT_W'(k))           msg_d[k*WORD_WIDTH +: WORD_WIDTH] = i_word;
        if (cnt_q == CNT_W'(WPO + k))     key_d[k*WORD_WIDTH +: WORD_WIDTH] = i_word;
        if (cnt_q == CNT_W'(2*WPO + k))   mod_d[k*WORD_WIDTH +: WORD_WIDTH] = i_word;
      end
    end
  end

  // State, counter, error pulse and operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      msg_q   <= '0;
      key_q   <= '0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      mod_q   <= mod_d;
    end
  end

endmodule

// File: tb/tb_rsa_word_loader.sv
// Bench for rsa_word_loader: transaction-level scoreboard plus directed and
// table-driven frame sequences.
module tb_rsa_word_loader;

  localparam int MW    = 256;
  localparam int WW    = 32;
  localparam int WPO   = MW / WW;
  localparam int FRAME = 3 * WPO;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [WW-1:0] i_word;
  logic          i_last;
  logic          o_valid;
  logic          o_ready;
  logic [MW-1:0] o_msg;
  logic [MW-1:0] o_key;
  logic [MW-1:0] o_modulus;
  logic          o_frame_err;

  rsa_word_loader #(.MOD_WIDTH(MW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_word(i_word), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_msg(o_msg), .o_key(o_key), .o_modulus(o_modulus),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_hs  = 0;
  int n_err = 0;

  logic [WW-1:0] frame_w [2*FRAME];

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Operand value from frame_w words: word k of operand op is bits [32k +: 32].
  function automatic logic [MW-1:0] exp_op(input int base, input int op);
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < WPO; k++) v[k*WW +: WW] = frame_w[base + op*WPO + k];
    return v;
  endfunction

  // Scoreboard: collects accepted words and predicts frames, drops and outputs.
  logic [WW-1:0] mq [$];
  logic          m_send = 1'b0;
  logic          m_err  = 1'b0;
  logic [MW-1:0] e_msg, e_key, e_mod;
  always @(negedge clk) begin
    logic err_next;
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_err  = 1'b0;
    end else begin
      chk1("sb_frame_err", o_frame_err, m_err);
      if (o_frame_err) n_err++;
      chk1("sb_o_valid", o_valid, m_send);
      chk1("sb_i_ready", i_ready, !m_send);
      if (m_send) begin
        chk("sb_msg", o_msg, e_msg);
        chk("sb_key", o_key, e_key);
        chk("sb_mod", o_modulus, e_mod);
      end
      err_next = 1'b0;
      if (m_send) begin
        if (o_ready) begin
          m_send = 1'b0;
          n_hs++;
        end
      end else if (i_valid) begin
        mq.push_back(i_word);
        if (i_last) begin
          if (mq.size() == FRAME) begin
            e_msg = '0; e_key = '0; e_mod = '0;
            for (int k = 0; k < WPO; k++) begin
              e_msg[k*WW +: WW] = mq[k];
              e_key[k*WW +: WW] = mq[WPO + k];
              e_mod[k*WW +: WW] = mq[2*WPO + k];
            end
            m_send = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          mq.delete();
        end else if (mq.size() == FRAME) begin
          err_next = 1'b1;
          mq.delete();
        end
      end
      m_err = err_next;
    end
  end

  // Present one word (after optional random idle cycles) until it is accepted.
  task automatic send_word(input logic [WW-1:0] w, input logic last, input int gap_pct);
    bit acc;
    int budget;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      i_valid = 1'b0;
      @(posedge clk); #1;
    end
    i_valid = 1'b1;
    i_word  = w;
    i_last  = last;
    budget  = 0;
    forever begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk); #1;
      if (acc) break;
      budget++;
      if (budget > 200) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic send_seq(input int start, input int n, input bit last_end, input int gap_pct);
    for (int i = 0; i < n; i++)
      send_word(frame_w[start + i], last_end && (i == n - 1), gap_pct);
  endtask

  task automatic chk_frame(input string name, input int base);
    chk1({name, "_valid"}, o_valid, 1'b1);
    chk({name, "_msg"}, o_msg, exp_op(base, 0));
    chk({name, "_key"}, o_key, exp_op(base, 1));
    chk({name, "_mod"}, o_modulus, exp_op(base, 2));
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < 2*FRAME; i++) frame_w[i] = $urandom;
  endtask

  typedef struct {
    int nwords;
    bit last_end;
    int gap;
    int bp;
    int exp_hs;
    int exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [MW-1:0] ref_msg, ref_key, ref_mod;
    int h0, e0;

    vecs[0] = '{nwords: 24, last_end: 1, gap: 0,  bp: 0, exp_hs: 1, exp_err: 0};
    vecs[1] = '{nwords: 24, last_end: 1, gap: 50, bp: 3, exp_hs: 1, exp_err: 0};
    vecs[2] = '{nwords: 1,  last_end: 1, gap: 0,  bp: 0, exp_hs: 0, exp_err: 1};
    vecs[3] = '{nwords: 23, last_end: 1, gap: 30, bp: 0, exp_hs: 0, exp_err: 1};
    vecs[4] = '{nwords: 24, last_end: 0, gap: 0,  bp: 0, exp_hs: 0, exp_err: 1};
    vecs[5] = '{nwords: 25, last_end: 1, gap: 0,  bp: 0, exp_hs: 0, exp_err: 2};
    vecs[6] = '{nwords: 48, last_end: 1, gap: 20, bp: 5, exp_hs: 1, exp_err: 1};

    rst = 1'b1; i_valid = 1'b0; i_word = '0; i_last = 1'b0; o_ready = 1'b1;

    // Reset state, including i_ready already high during reset.
    #1;
    chk1("rst_i_ready", i_ready, 1'b1);
    chk1("rst_o_valid", o_valid, 1'b0);
    chk1("rst_frame_err", o_frame_err, 1'b0);
    chk("rst_msg", o_msg, '0);
    chk("rst_key", o_key, '0);
    chk("rst_mod", o_modulus, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_i_ready", i_ready, 1'b1);

    // Well-formed frame with word index as data.
    for (int i = 0; i < FRAME; i++) frame_w[i] = WW'(i);
    send_seq(0, FRAME, 1'b1, 0);
    chk_frame("idx", 0);
    ref_msg = '0;
    for (int k = 0; k < WPO; k++) ref_msg[k*WW +: WW] = WW'(k);
    chk("idx_msg_const", o_msg, ref_msg);
    chk("idx_key_low", MW'(o_key[WW-1:0]), MW'(8));
    chk("idx_mod_top", MW'(o_modulus[MW-1 -: WW]), MW'(23));
    chk1("idx_i_ready_low", i_ready, 1'b0);
    @(posedge clk); #1;
    chk1("idx_valid_one_cycle", o_valid, 1'b0);
    chk1("idx_i_ready_back", i_ready, 1'b1);

    // Backpressure: ten cycles of o_ready low keep outputs stable.
    randomize_frame();
    o_ready = 1'b0;
    send_seq(0, FRAME, 1'b1, 0);
    for (int c = 0; c < 10; c++) begin
      chk_frame("bp_hold", 0);
      chk1("bp_i_ready", i_ready, 1'b0);
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    chk1("bp_valid_at_release", o_valid, 1'b1);
    @(posedge clk); #1;
    chk1("bp_valid_after_hs", o_valid, 1'b0);
    chk1("bp_i_ready_after_hs", i_ready, 1'b1);

    // Short frame, then a known-good frame.
    randomize_frame();
    send_seq(0, 6, 1'b1, 0);
    chk1("short_err", o_frame_err, 1'b1);
    chk1("short_no_valid", o_valid, 1'b0);
    @(posedge clk); #1;
    chk1("short_err_one_cycle", o_frame_err, 1'b0);
    for (int i = 0; i < FRAME; i++) frame_w[i] = '0;
    frame_w[0] = 32'h1;
    frame_w[WPO] = 32'h10001;
    for (int i = 2*WPO; i < FRAME; i++) frame_w[i] = 32'hFFFF_FFFF;
    send_seq(0, FRAME, 1'b1, 0);
    chk("short_next_msg", o_msg, MW'(1));
    chk("short_next_key", o_key, MW'(32'h10001));
    chk("short_next_mod", o_modulus, {MW{1'b1}});
    chk1("short_next_valid", o_valid, 1'b1);
    @(posedge clk); #1;

    // Long frame, then a correct frame.
    randomize_frame();
    send_seq(0, FRAME, 1'b0, 0);
    chk1("long_err", o_frame_err, 1'b1);
    chk1("long_no_valid", o_valid, 1'b0);
    send_seq(FRAME, FRAME, 1'b1, 0);
    chk_frame("long_next", FRAME);
    @(posedge clk); #1;

    // Asynchronous reset at word 12.
    randomize_frame();
    send_seq(0, 12, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk1("rst_mid_valid", o_valid, 1'b0);
    chk("rst_mid_msg", o_msg, '0);
    chk("rst_mid_key", o_key, '0);
    chk("rst_mid_mod", o_modulus, '0);
    @(posedge clk); #1 rst = 1'b0;
    send_seq(FRAME, FRAME, 1'b1, 0);
    chk_frame("rst_mid_next", FRAME);
    @(posedge clk); #1;

    // Asynchronous reset while holding in SEND.
    randomize_frame();
    o_ready = 1'b0;
    send_seq(0, FRAME, 1'b1, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("rst_send_valid", o_valid, 1'b0);
    chk1("rst_send_i_ready", i_ready, 1'b1);
    chk("rst_send_msg", o_msg, '0);
    chk("rst_send_mod", o_modulus, '0);
    @(posedge clk); #1 rst = 1'b0;
    o_ready = 1'b1;
    send_seq(FRAME, FRAME, 1'b1, 0);
    chk_frame("rst_send_next", FRAME);
    @(posedge clk); #1;

    // Gapped input gives the same result as the unbroken frame.
    randomize_frame();
    send_seq(0, FRAME, 1'b1, 0);
    ref_msg = o_msg; ref_key = o_key; ref_mod = o_modulus;
    chk_frame("gap_ref", 0);
    @(posedge clk); #1;
    e0 = n_err;
    send_seq(0, FRAME, 1'b1, 50);
    chk_frame("gap", 0);
    chk("gap_same_msg", o_msg, exp_op(0, 0));
    chk("gap_same_key", o_key, exp_op(0, 1));
    chk("gap_same_mod", o_modulus, exp_op(0, 2));
    @(posedge clk); #1;
    chk_int("gap_no_err", n_err - e0, 0);

    // Table of randomized framing cases.
    for (int v = 0; v < 7; v++) begin
      h0 = n_hs;
      e0 = n_err;
      randomize_frame();
      o_ready = (vecs[v].bp == 0);
      send_seq(0, vecs[v].nwords, vecs[v].last_end, vecs[v].gap);
      for (int c = 0; c < vecs[v].bp; c++) begin
        @(posedge clk); #1;
      end
      o_ready = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
      end
      chk_int($sformatf("vec%0d_handshakes", v), n_hs - h0, vecs[v].exp_hs);
      chk_int($sformatf("vec%0d_frame_errs", v), n_err - e0, vecs[v].exp_err);
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
